// File: rtl/coin_pkg.sv
// rtl/coin_pkg.sv - coin code type and constants shared by the encoder and the vending FSM
package coin_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'd0;
    localparam coin_t COIN_5    = 2'd1;
    localparam coin_t COIN_10   = 2'd2;
    localparam coin_t COIN_RET  = 2'd3;

    localparam int DEB_CNT_W = 8;

    // Running credit in units of 5, saturating; a refund grant zeroes it.
    function automatic logic [7:0] total_next(input logic [7:0] cur, input coin_t code);
        logic [8:0] sum;
        logic [7:0] res;
        sum = {1'b0, cur};
        res = cur;
        case (code)
            COIN_5:   sum = {1'b0, cur} + 9'd1;
            COIN_10:  sum = {1'b0, cur} + 9'd2;
            default:  sum = {1'b0, cur};
        endcase
        if (code == COIN_RET) begin
            res = 8'd0;
        end else if (sum[8]) begin
            res = 8'hff;
        end else begin
            res = sum[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-flop synchroniser, stability debouncer and rising-edge pulse for one raw input
module coin_debounce
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam logic [DEB_CNT_W-1:0] LAST_CNT = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 level_q;
    logic                 level_d;
    logic                 level_prev_q;
    logic [DEB_CNT_W-1:0] cnt_q;
    logic [DEB_CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= raw_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == LAST_CNT) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + DEB_CNT_W'(1);
            end
        end
    end

    assign rise_o = level_q & ~level_prev_q;

endmodule

// File: rtl/coin_encoder.sv
// rtl/coin_encoder.sv - debounced coin/return front end with pending queues and priority arbiter
// Optional running-credit output enabled by COIN_ENC_TOTAL_EN.
module coin_encoder
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int QUEUE_MAX       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw5,
    input  logic       raw10,
    input  logic       rawret,
    input  logic       inhibit,
    output coin_t      coin,
    output logic       ovf
`ifdef COIN_ENC_TOTAL_EN
    ,
    output logic [7:0] total
`endif
);

    localparam int            QW   = $clog2(QUEUE_MAX + 1);
    localparam logic [QW-1:0] QMAX = QW'(QUEUE_MAX);

    logic          ev5;
    logic          ev10;
    logic          evret;

    logic [QW-1:0] cnt5_q;
    logic [QW-1:0] cnt5_d;
    logic [QW-1:0] cnt10_q;
    logic [QW-1:0] cnt10_d;
    logic          ret_q;
    logic          ret_d;
    logic          ovf_q;
    logic          ovf_d;
    coin_t         coin_q;
    coin_t         coin_d;

    logic          grant5;
    logic          grant10;
    logic          grant_ret;
    logic          drop5;
    logic          drop10;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw5),
        .rise_o (ev5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (raw10),
        .rise_o (ev10)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debret (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (rawret),
        .rise_o (evret)
    );

    // A simultaneous event and grant cancel, so a saturated counter never drops in that case.
    function automatic logic [QW-1:0] next_cnt(input logic [QW-1:0] cnt, input logic ev,
                                               input logic gnt);
        logic [QW-1:0] res;
        res = cnt;
        if (ev && !gnt && cnt != QMAX) begin
            res = cnt + QW'(1);
        end else if (gnt && !ev) begin
            res = cnt - QW'(1);
        end
        return res;
    endfunction

    always_comb begin
        grant10   = 1'b0;
        grant5    = 1'b0;
        grant_ret = 1'b0;
        coin_d    = COIN_NONE;
        if (!inhibit) begin
            if (cnt10_q != '0) begin
                grant10 = 1'b1;
                coin_d  = COIN_10;
            end else if (cnt5_q != '0) begin
                grant5 = 1'b1;
                coin_d = COIN_5;
            end else if (ret_q) begin
                // Refund only once every credited coin has gone out.
                grant_ret = 1'b1;
                coin_d    = COIN_RET;
            end
        end

        drop5   = ev5 && !grant5 && (cnt5_q == QMAX);
        drop10  = ev10 && !grant10 && (cnt10_q == QMAX);
        cnt5_d  = next_cnt(cnt5_q, ev5, grant5);
        cnt10_d = next_cnt(cnt10_q, ev10, grant10);
        ovf_d   = ovf_q | drop5 | drop10;

        ret_d = ret_q;
        if (evret) begin
            ret_d = 1'b1;
        end else if (grant_ret) begin
            ret_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt5_q  <= '0;
            cnt10_q <= '0;
            ret_q   <= 1'b0;
            ovf_q   <= 1'b0;
            coin_q  <= COIN_NONE;
        end else begin
            cnt5_q  <= cnt5_d;
            cnt10_q <= cnt10_d;
            ret_q   <= ret_d;
            ovf_q   <= ovf_d;
            coin_q  <= coin_d;
        end
    end

    assign coin = coin_q;
    assign ovf  = ovf_q;

`ifdef COIN_ENC_TOTAL_EN
    logic [7:0] total_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_q <= 8'd0;
        end else begin
            total_q <= total_next(total_q, coin_d);
        end
    end

    assign total = total_q;
`endif

endmodule
